// File: rtl/store_buffer.sv
// Posted-write store buffer between load/store port and data memory; stores retire same edge, loads are combinational.
// Drains one entry per cycle when no load owns the memory port; stall asserts on a store while full.
`timescale 1ns/1ps
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] add,
  input  logic [DW-1:0] write_data,
  input  logic          memwrite,
  input  logic          memread,
  output logic [DW-1:0] read_data,
  output logic          stall,
  output logic          empty,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_memwrite,
  output logic          mem_memread,
  input  logic [DW-1:0] mem_read_data
);

  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic          full;
  logic          push;
  logic          drain;
  logic          fwd_hit;
  logic [PW-1:0] fwd_idx;
  logic [PW-1:0] scan_idx;

  assign full  = (count_q == FULL);
  assign empty = (count_q == '0);
  assign stall = memwrite & full;
  assign push  = memwrite & ~full;
  // A load owns the memory port, so it suppresses the drain for that cycle.
  assign drain = ~empty & ~memread;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(drain);
    if (push)  tail_d = tail_q + 1'b1;
    if (drain) head_d = head_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= add;
      data_q[tail_q] <= write_data;
    end
  end

  // Scan oldest to youngest so the last match found is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (addr_q[scan_idx] == add)) begin
        fwd_hit = 1'b1;
        fwd_idx = scan_idx;
      end
    end
  end

  always_comb begin
    read_data = '0;
    if (memread) begin
      read_data = fwd_hit ? data_q[fwd_idx] : mem_read_data;
    end
  end

  always_comb begin
    mem_add        = '0;
    mem_write_data = '0;
    mem_memwrite   = 1'b0;
    mem_memread    = 1'b0;
    if (memread) begin
      mem_add     = add;
      mem_memread = 1'b1;
    end else if (drain) begin
      mem_add        = addr_q[head_q];
      mem_write_data = data_q[head_q];
      mem_memwrite   = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, drain, fill/stall, forwarding, miss path, wrap-around.
`timescale 1ns/1ps
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] add;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [31:0] read_data;
  logic        stall;
  logic        empty;
  logic [31:0] mem_add;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .add            (add),
    .write_data     (write_data),
    .memwrite       (memwrite),
    .memread        (memread),
    .read_data      (read_data),
    .stall          (stall),
    .empty          (empty),
    .mem_add        (mem_add),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are checked 1ns later.
  task automatic drive(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] mrd);
    memwrite      = we;
    memread       = re;
    add           = a;
    write_data    = d;
    mem_read_data = mrd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b1;

    // Reset discards a pending store; the write presented in the reset cycle still goes out.
    drive(1, 0, 32'd5, 32'h55, 0);
    check("rst_pre_stall", stall, 1'b0);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("rst_cycle_memwrite", mem_memwrite, 1'b1);
    check("rst_cycle_add", mem_add, 32'd5);
    tick();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_stall", stall, 1'b0);
    check("rst_memwrite", mem_memwrite, 1'b0);
    check("rst_mem_add", mem_add, 32'd0);
    tick();
    check("rst_no_late_write", mem_memwrite, 1'b0);

    // Single store drains the following cycle.
    drive(1, 0, 32'd3, 32'hA5, 0);
    check("single_c0_empty", empty, 1'b1);
    check("single_c0_memwrite", mem_memwrite, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("single_c1_memwrite", mem_memwrite, 1'b1);
    check("single_c1_add", mem_add, 32'd3);
    check("single_c1_data", mem_write_data, 32'hA5);
    check("single_c1_empty", empty, 1'b0);
    tick();
    check("single_c2_empty", empty, 1'b1);
    check("single_c2_memwrite", mem_memwrite, 1'b0);

    // Fill with loads holding off drain; fifth store stalls.
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 32'd10 + k, 32'd1 + k, 32'hEE);
      check("fill_stall", stall, (k == 4));
      check("fill_memwrite", mem_memwrite, 1'b0);
      check("fill_mem_add", mem_add, 32'd10 + k);
      check("fill_read_miss", read_data, 32'hEE);
      if (k == 4) check("fill_count_full", dut.count_q, 3'd4);
      tick();
    end
    check("fill_count_held", dut.count_q, 3'd4);
    drive(1, 0, 32'd14, 32'd5, 0);
    check("drain0_stall", stall, 1'b1);
    check("drain0_add", mem_add, 32'd10);
    check("drain0_data", mem_write_data, 32'd1);
    tick();
    drive(1, 0, 32'd14, 32'd5, 0);
    check("drain1_stall", stall, 1'b0);
    check("drain1_add", mem_add, 32'd11);
    check("drain1_data", mem_write_data, 32'd2);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("drain_rest_memwrite", mem_memwrite, 1'b1);
      check("drain_rest_add", mem_add, 32'd12 + k);
      check("drain_rest_data", mem_write_data, 32'd3 + k);
      tick();
    end
    check("drain_done_empty", empty, 1'b1);

    // Forwarding picks the youngest; a same-cycle store is invisible to the load.
    drive(1, 1, 32'd7, 32'h1, 32'h77);
    check("fwd_c0_miss", read_data, 32'h77);
    tick();
    drive(1, 1, 32'd7, 32'h2, 32'h77);
    check("fwd_c1_old", read_data, 32'h1);
    tick();
    drive(0, 1, 32'd7, 0, 32'h77);
    check("fwd_youngest", read_data, 32'h2);
    tick();

    // Miss path passes through to memory.
    drive(0, 1, 32'd9, 0, 32'h33);
    check("miss_read_data", read_data, 32'h33);
    check("miss_mem_add", mem_add, 32'd9);
    check("miss_memread", mem_memread, 1'b1);
    check("miss_memwrite", mem_memwrite, 1'b0);
    tick();

    // Both stores to address 7 drain separately, in order.
    drive(0, 0, 32'd7, 0, 32'h33);
    check("no_load_read_zero", read_data, 32'h0);
    check("dup0_add", mem_add, 32'd7);
    check("dup0_data", mem_write_data, 32'h1);
    check("dup0_memread", mem_memread, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("dup1_add", mem_add, 32'd7);
    check("dup1_data", mem_write_data, 32'h2);
    tick();
    check("dup_done_empty", empty, 1'b1);

    // Simultaneous push and drain for ten stores; pointers wrap.
    drive(1, 0, 32'd0, 32'd100, 0);
    check("wrap_first_memwrite", mem_memwrite, 1'b0);
    tick();
    for (int k = 1; k < 10; k++) begin
      drive(1, 0, k, 32'd100 + k, 0);
      check("wrap_stall", stall, 1'b0);
      check("wrap_count", dut.count_q, 3'd1);
      check("wrap_memwrite", mem_memwrite, 1'b1);
      check("wrap_add", mem_add, k - 1);
      check("wrap_data", mem_write_data, 32'd99 + k);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    check("wrap_last_add", mem_add, 32'd9);
    check("wrap_last_data", mem_write_data, 32'd109);
    tick();
    check("wrap_empty", empty, 1'b1);
    check("wrap_idle_memwrite", mem_memwrite, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the datapath's load/store port and `data_memory`. Stores retire into a small FIFO in one cycle and drain to memory in the background, one entry per cycle, whenever the memory port is not needed by a load. Loads are served combinationally. The youngest matching buffered store is forwarded; otherwise the load passes through to memory. The block is transparent to the datapath except for a `stall` output when the buffer is full.

## Interface
- `DEPTH`, 4: number of buffered stores; power of two, ≥2.
- `AW`, 32: address width (word address, same indexing as `data_memory`).
- `DW`, 32: data width.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  one clock; reset is synchronous and active-low.
- `add`  in  AW  datapath load/store address.
- `write_data`  in  DW  datapath store data.
- `memwrite`  in  1  datapath store request.
- `memread`  in  1  datapath load request.
- `read_data`  out  DW  load result (combinational).
- `stall`  out  1  store not accepted this cycle; datapath must hold.
- `empty`  out  1  buffer holds no entries.
- `mem_add`  out  AW  to `data_memory.add`.
- `mem_write_data`  out  DW  to `data_memory.write_data`.
- `mem_memwrite`  out  1  to `data_memory.memwrite`.
- `mem_memread`  out  1  to `data_memory.memread`.
- `mem_read_data`  in  DW  from `data_memory.read_data`.

## Operation
- State: entry arrays `addr_q[DEPTH]` and `data_q[DEPTH]`, `head`/`tail` pointers (log2 DEPTH bits, wrap naturally), and `count` (log2 DEPTH + 1 bits).
- **Push:** `memwrite & (count != DEPTH)` writes {`add`,`write_data`} at `tail`, then `tail++`.
- **Stall:** `stall = memwrite & (count == DEPTH)`. This is purely combinational. A same-cycle drain does not un-stall; the store is accepted the following cycle.
- **Drain:** `drain = (count != 0) & ~memread`. The block drives `mem_memwrite=1`, `mem_add=addr_q[head]` and `mem_write_data=data_q[head]`, then `head++` at the same edge.
- **Mem port mux:**
  - When `memread=1`: `mem_add=add`, `mem_memread=1`, `mem_memwrite=0`.
  - When idle: `mem_add=0`, `mem_write_data=0`.
- **Load forwarding:** compare `add` against all valid entries on the full AW bits. The hit is the youngest valid match, searched from `tail-1` back toward `head`.
  - Hit: `read_data=data_q[hit]`.
  - Miss: `read_data=mem_read_data`.
  - `memread=0`: `read_data=0`.
- **Count update:** `count += push - drain`. Push and drain may occur in the same cycle.
- **Ordering:** stores reach memory strictly in issue order. There is no coalescing; repeated stores to one address each drain.
- **Load and store in the same cycle** (`memread & memwrite`) is legal:
  - The load forwards from state before the push; the new store is not visible to the load.
  - The push proceeds unless stalled.
  - Drain is suppressed.
- An entry pushed at edge N is eligible to drain in the cycle after N.

## Timing
- **Reset** (`reset==0` at posedge): `head=tail=count=0`. All buffered stores are discarded and never reach memory.
  - Following cycle: `empty=1`, `mem_memwrite=0`, `stall=0`.
  - Entry arrays need not be cleared.
- **Reset mid-drain:** the drain write presented in the reset cycle still reaches `data_memory` (it samples `memwrite` at that edge). No further drains follow.
- **Store latency:** retires in 0 cycles (same edge). Earliest memory update is 1 cycle after push, delayed by any pending older entries and by every load cycle.
- **Load latency:** 0 cycles (combinational through forward mux or memory).
- **Throughput:** 1 push and 1 drain per cycle.
- **Full:** `count==DEPTH` blocks push. **Empty:** `count==0` blocks drain.
- Pointers wrap modulo DEPTH without special handling.
- **Drain starvation:** a continuous load stream starves drain indefinitely. This is by design; the datapath is responsible.

## Test plan
- **Reset:** drive `reset=0` for 1 cycle with a store pending → next cycle `empty=1`, `stall=0`, `mem_memwrite=0`; no memory write issued afterwards.
- **Single store drain:** store `write_data=0xA5` to `add=3` in cycle 0, idle after → cycle 1 `mem_memwrite=1`, `mem_add=3`, `mem_write_data=0xA5`; cycle 2 `empty=1`, `mem_memwrite=0`.
- **Fill/stall (DEPTH=4):** hold `memread=1`, `memwrite=1` for 5 cycles, stores 1..5 to addresses 10..14:
  - Cycles 0–3 accepted; cycle 4 `stall=1`, count stays 4.
  - Drop `memread` → drains addresses 10,11,12,13 in order on consecutive cycles.
  - Store 5 is accepted on the cycle after the first drain.
- **Forwarding youngest:** store 0x1 to `add=7`, then 0x2 to `add=7`, then load `add=7` while both entries are still buffered (hold `memread`) → `read_data=0x2`.
- **Miss path:** buffer holds `add=7`; load `add=9` with `mem_read_data=0x33` → `read_data=0x33`, `mem_add=9`, `mem_memread=1`, `mem_memwrite=0`.
- **Wrap-around and simultaneity:** push and drain on the same cycle for 10 consecutive stores (addresses 0..9) → `count` steady at 1, memory sees addresses 0..9 in order, `stall` never asserted.
